// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bclk/lrck/sdata and deserialises left/right words into signed 32-bit samples.
// Optional `MONO_SUM_EN adds mono_out = (left>>>1)+(right>>>1), updated together with tick.
module i2s_rx #(
    parameter int SAMPLE_BITS = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i2s_bclk,
    input  logic               i2s_lrck,
    input  logic               i2s_sdata,
    output logic signed [31:0] left_out,
    output logic signed [31:0] right_out,
    output logic               tick,
    output logic               frame_err
`ifdef MONO_SUM_EN
    ,
    output logic signed [31:0] mono_out
`endif
);

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    state_t                   state;
    logic                     bclk_p0, bclk_p1, bclk_p2;
    logic                     lrck_p0, lrck_p1;
    logic                     sdata_p0, sdata_p1;
    logic                     lr_prev;
    logic [SAMPLE_BITS-1:0]   sr, sr_nxt;
    logic [CNT_W-1:0]         bitcnt, cnt_nxt;
    logic signed [31:0]       stage;
    logic signed [31:0]       closed;
    logic                     rise, slot_close, short_slot;

    // Left-align a possibly short word (zero-pad missing LSBs), then sign-extend to 32 bits.
    function automatic logic signed [31:0] close_word(input logic [SAMPLE_BITS-1:0] s,
                                                      input logic [CNT_W-1:0] n);
        logic signed [SAMPLE_BITS-1:0] w;
        logic signed [31:0]            r;
        w = $signed(s << (CNT_W'(SAMPLE_BITS) - n));
        r = w;
        return r;
    endfunction

`ifdef MONO_SUM_EN
    function automatic logic signed [31:0] mono_sum(input logic signed [31:0] a,
                                                    input logic signed [31:0] b);
        return (a >>> 1) + (b >>> 1);
    endfunction
`endif

    // Stage p0/p1: two-flop synchronisers; p2 holds the previous synced bclk for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_p0  <= 1'b0;
            bclk_p1  <= 1'b0;
            bclk_p2  <= 1'b0;
            lrck_p0  <= 1'b0;
            lrck_p1  <= 1'b0;
            sdata_p0 <= 1'b0;
            sdata_p1 <= 1'b0;
        end else begin
            bclk_p0  <= i2s_bclk;
            bclk_p1  <= bclk_p0;
            bclk_p2  <= bclk_p1;
            lrck_p0  <= i2s_lrck;
            lrck_p1  <= lrck_p0;
            sdata_p0 <= i2s_sdata;
            sdata_p1 <= sdata_p0;
        end
    end

    assign rise       = bclk_p1 & ~bclk_p2;
    assign slot_close = rise && (lrck_p1 != lr_prev);

    // The bit sampled on the closing rise still belongs to the old slot, so it is shifted in first.
    always_comb begin
        sr_nxt  = sr;
        cnt_nxt = bitcnt;
        if (bitcnt < CNT_W'(SAMPLE_BITS)) begin
            sr_nxt  = {sr[SAMPLE_BITS-2:0], sdata_p1};
            cnt_nxt = bitcnt + 1'b1;
        end
    end

    assign closed     = close_word(sr_nxt, cnt_nxt);
    assign short_slot = cnt_nxt < CNT_W'(SAMPLE_BITS);

    // Capture FSM and output registers, advanced only on a synced bclk rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SYNC;
            lr_prev   <= 1'b0;
            sr        <= '0;
            bitcnt    <= '0;
            stage     <= '0;
            left_out  <= '0;
            right_out <= '0;
            tick      <= 1'b0;
            frame_err <= 1'b0;
`ifdef MONO_SUM_EN
            mono_out  <= '0;
`endif
        end else begin
            tick      <= 1'b0;
            frame_err <= 1'b0;
            if (rise) begin
                lr_prev <= lrck_p1;
                if (slot_close) begin
                    sr     <= '0;
                    bitcnt <= '0;
                    case (state)
                        SYNC: begin
                            if (!lrck_p1) state <= LEFT;
                        end
                        LEFT: begin
                            frame_err <= short_slot;
                            stage     <= closed;
                            state     <= RIGHT;
                        end
                        RIGHT: begin
                            frame_err <= short_slot;
                            left_out  <= stage;
                            right_out <= closed;
                            tick      <= 1'b1;
`ifdef MONO_SUM_EN
                            mono_out  <= mono_sum(stage, closed);
`endif
                            state     <= LEFT;
                        end
                        default: state <= SYNC;
                    endcase
                end else begin
                    sr     <= sr_nxt;
                    bitcnt <= cnt_nxt;
                end
            end
        end
    end

endmodule
